// File: rtl/tiny_nn_core_ctrl_if.sv
// Command, result and core-strobe bundle between the tiny_nn_core sequencer and its neighbours.
// slave is the sequencer's view; master is the command source / result sink / core side.
interface tiny_nn_core_ctrl_if #(
    parameter int unsigned FpWidth     = 16,
    parameter int unsigned ArrayWidth  = 4,
    parameter int unsigned ArrayHeight = 2
);
    typedef logic [FpWidth-1:0] fp_t;

    logic                               cmd_valid;
    logic                               cmd_ready;
    logic [1:0]                         cmd_op;
    fp_t                                cmd_data;
    fp_t                                val;
    logic [ArrayHeight-1:0]             val_shift;
    fp_t                                param;
    logic [ArrayHeight*ArrayWidth-1:0]  param_write;
    logic                               mul_row_sel;
    logic                               mul_en;
    logic [1:0]                         accumulate_en;
    fp_t                                accumulate;
    logic                               result_valid;
    logic                               result_ready;
    fp_t                                result;

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, accumulate, result_ready,
        output cmd_ready, val, val_shift, param, param_write,
               mul_row_sel, mul_en, accumulate_en, result_valid, result
    );

    modport master (
        output cmd_valid, cmd_op, cmd_data, accumulate, result_ready,
        input  cmd_ready, val, val_shift, param, param_write,
               mul_row_sel, mul_en, accumulate_en, result_valid, result
    );
endinterface

// File: rtl/tiny_nn_core_ctrl.sv
// Command sequencer for tiny_nn_core: loads parameters/values, runs the fixed
// multiply/accumulate schedule and returns the dot product on a valid/ready port.
module tiny_nn_core_ctrl #(
    parameter int unsigned ValArrayWidth  = 4,
    parameter int unsigned ValArrayHeight = 2,
    parameter int unsigned FpWidth        = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    tiny_nn_core_ctrl_if.slave bus
);
    localparam int unsigned NumParams = ValArrayWidth * ValArrayHeight;
    localparam int unsigned ParamIdxW = $clog2(NumParams);
    localparam int unsigned ValCntW   = $clog2(ValArrayWidth);
    localparam int unsigned ValRowW   = (ValArrayHeight > 1) ? $clog2(ValArrayHeight) : 1;

    localparam logic [1:0] OpLoadParam = 2'd0;
    localparam logic [1:0] OpLoadVal   = 2'd1;
    localparam logic [1:0] OpRun       = 2'd2;
    localparam logic [1:0] OpClear     = 2'd3;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StMul0   = 3'd1;
    localparam logic [2:0] StMul1   = 3'd2;
    localparam logic [2:0] StAcc0   = 3'd3;
    localparam logic [2:0] StAcc1   = 3'd4;
    localparam logic [2:0] StFinal  = 3'd5;
    localparam logic [2:0] StResult = 3'd6;

    logic [2:0]           state_q, state_d;
    logic [ParamIdxW-1:0] param_idx_q, param_idx_d;
    logic [ValCntW-1:0]   val_cnt_q, val_cnt_d;
    logic [ValRowW-1:0]   val_row_q, val_row_d;

    logic                      fire;
    logic                      ready;
    logic [NumParams-1:0]      param_write;
    logic [ValArrayHeight-1:0] val_shift;
    logic                      mul_en;
    logic                      mul_row_sel;
    logic [1:0]                acc_en;
    logic                      result_valid;
    logic [FpWidth-1:0]        result;

    assign fire = bus.cmd_valid && (state_q == StIdle);

    // State and load-pointer registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            param_idx_q <= '0;
            val_cnt_q   <= '0;
            val_row_q   <= '0;
        end else begin
            state_q     <= state_d;
            param_idx_q <= param_idx_d;
            val_cnt_q   <= val_cnt_d;
            val_row_q   <= val_row_d;
        end
    end

    // Command decode, schedule sequencing and core strobes
    always_comb begin
        state_d      = state_q;
        param_idx_d  = param_idx_q;
        val_cnt_d    = val_cnt_q;
        val_row_d    = val_row_q;
        ready        = 1'b0;
        param_write  = '0;
        val_shift    = '0;
        mul_en       = 1'b0;
        mul_row_sel  = 1'b0;
        acc_en       = 2'b00;
        result_valid = 1'b0;
        result       = '0;

        case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (fire) begin
                    case (bus.cmd_op)
                        OpLoadParam: begin
                            // Slot index is column-major: x*H + y
                            param_write = NumParams'(1) << param_idx_q;
                            param_idx_d = (param_idx_q == ParamIdxW'(NumParams - 1))
                                          ? '0 : param_idx_q + ParamIdxW'(1);
                        end
                        OpLoadVal: begin
                            val_shift = ValArrayHeight'(1) << val_row_q;
                            if (val_cnt_q == ValCntW'(ValArrayWidth - 1)) begin
                                val_cnt_d = '0;
                                val_row_d = (val_row_q == ValRowW'(ValArrayHeight - 1))
                                            ? '0 : val_row_q + ValRowW'(1);
                            end else begin
                                val_cnt_d = val_cnt_q + ValCntW'(1);
                            end
                        end
                        OpRun:   state_d = StMul0;
                        OpClear: begin
                            param_idx_d = '0;
                            val_cnt_d   = '0;
                            val_row_d   = '0;
                        end
                        default: ;
                    endcase
                end
            end
            // row_sel=1 addresses core row 0; MUL1's partial-sum write is rewritten in ACC1
            StMul0: begin
                mul_en      = 1'b1;
                mul_row_sel = 1'b1;
                state_d     = StMul1;
            end
            StMul1: begin
                mul_en  = 1'b1;
                acc_en  = 2'b01;
                state_d = StAcc0;
            end
            StAcc0: begin
                mul_row_sel = 1'b1;
                acc_en      = 2'b01;
                state_d     = StAcc1;
            end
            StAcc1: begin
                acc_en  = 2'b01;
                state_d = StFinal;
            end
            StFinal: begin
                acc_en  = 2'b10;
                state_d = StResult;
            end
            StResult: begin
                result_valid = 1'b1;
                result       = bus.accumulate;
                if (bus.result_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.cmd_ready     = ready;
    assign bus.val           = bus.cmd_data;
    assign bus.param         = bus.cmd_data;
    assign bus.val_shift     = val_shift;
    assign bus.param_write   = param_write;
    assign bus.mul_en        = mul_en;
    assign bus.mul_row_sel   = mul_row_sel;
    assign bus.accumulate_en = acc_en;
    assign bus.result_valid  = result_valid;
    assign bus.result        = result;
endmodule

// File: tb/tb_tiny_nn_core_ctrl.sv
// Bench for tiny_nn_core_ctrl: a small Q8.8 core model answers the strobes, expected
// dot products go into a queue that an independent monitor drains on each result handshake.
module tb_tiny_nn_core_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tiny_nn_core_ctrl_if bus ();

    tiny_nn_core_ctrl dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Core model: Q8.8 params/values, column-major param slots, shift-left value rows
    logic [15:0] prm  [2][4] = '{default: '0};
    logic [15:0] vals [2][4] = '{default: '0};
    logic [15:0] prod [2][4] = '{default: '0};
    logic [15:0] psum [2]    = '{default: '0};
    logic [15:0] acc         = '0;

    function automatic logic [15:0] fxmul(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        return p[23:8];
    endfunction

    function automatic int row_of(input logic sel);
        return sel ? 0 : 1;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 8; k++)
            if (bus.param_write[k]) prm[k % 2][k / 2] <= bus.param;
        for (int r = 0; r < 2; r++)
            if (bus.val_shift[r]) begin
                for (int c = 0; c < 3; c++) vals[r][c] <= vals[r][c+1];
                vals[r][3] <= bus.val;
            end
        if (bus.mul_en)
            for (int c = 0; c < 4; c++)
                prod[row_of(bus.mul_row_sel)][c] <=
                    fxmul(prm[row_of(bus.mul_row_sel)][c], vals[row_of(bus.mul_row_sel)][c]);
        if (bus.accumulate_en == 2'b01)
            psum[row_of(bus.mul_row_sel)] <= prod[row_of(bus.mul_row_sel)][0] + prod[row_of(bus.mul_row_sel)][1]
                                           + prod[row_of(bus.mul_row_sel)][2] + prod[row_of(bus.mul_row_sel)][3];
        else if (bus.accumulate_en == 2'b10)
            acc <= psum[0] + psum[1];
    end
    assign bus.accumulate = acc;

    // Result monitor
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && bus.result_valid && bus.result_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0h with no result pending", bus.result);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", 32'(bus.result), 32'(e));
                end
            end
        end
    end

    // Issue one command, check its fire-cycle strobes, return at the next falling edge
    task automatic cmd(input logic [1:0] op, input logic [15:0] data,
                       input logic [7:0] exp_pw, input logic [1:0] exp_vs, input string name);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        #1;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({name, "_ready"}, 32'(bus.cmd_ready), 32'd1);
        chk({name, "_pw"}, 32'(bus.param_write), 32'(exp_pw));
        chk({name, "_vs"}, 32'(bus.val_shift), 32'(exp_vs));
        chk({name, "_pass"}, {bus.val, bus.param}, {data, data});
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    function automatic logic [3:0] sched(input int k);
        case (k)
            1: return 4'b1100;
            2: return 4'b1001;
            3: return 4'b0101;
            4: return 4'b0001;
            5: return 4'b0010;
            default: return 4'b0000;
        endcase
    endfunction

    // RUN, check the five schedule cycles, end at the expected result cycle (T+6)
    task automatic run_sched(input logic [15:0] exp);
        exp_q.push_back(exp);
        cmd(2'd2, 16'h0000, 8'h00, 2'b00, "run");
        for (int k = 1; k <= 5; k++) begin
            #1;
            chk($sformatf("sched%0d", k), {28'd0, bus.mul_en, bus.mul_row_sel, bus.accumulate_en},
                32'(sched(k)));
            chk($sformatf("sched%0d_busy", k), {30'd0, bus.cmd_ready, bus.result_valid}, 32'd0);
            @(negedge clk);
        end
        #1;
        chk("latency", 32'(bus.result_valid), 32'd1);
    endtask

    initial begin
        logic [15:0] r0;
        bit          seen;
        rst_n            = 1'b0;
        bus.cmd_valid    = 1'b0;
        bus.cmd_op       = 2'd0;
        bus.cmd_data     = 16'h0000;
        bus.result_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_strobes", {20'd0, bus.param_write, bus.val_shift, bus.mul_en,
                            bus.mul_row_sel, bus.accumulate_en}, 32'd0);
        chk("rst_result", {15'd0, bus.result_valid, bus.result}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Row 0 params 1.0, row 1 params 2.0 (slot order x*H+y)
        for (int i = 0; i < 8; i++)
            cmd(2'd0, (i % 2 == 0) ? 16'h0100 : 16'h0200, 8'(1 << i), 2'b00, $sformatf("param%0d", i));
        for (int j = 0; j < 8; j++)
            cmd(2'd1, (j < 4) ? 16'((j + 1) << 8) : 16'h0100, 8'h00, 2'(1 << (j / 4)),
                $sformatf("val%0d", j));

        // Dot product 1*10 + 2*4 = 18.0
        bus.result_ready = 1'b1;
        run_sched(16'h1200);
        @(negedge clk);
        #1;
        chk("post_result_idle", {15'd0, bus.cmd_ready, bus.result_valid, 15'd0}, {15'd0, 1'b1, 1'b0, 15'd0});
        chk("post_result_zero", 32'(bus.result), 32'd0);

        // Back-pressure with a 9th LOAD_PARAM queued behind the result
        bus.result_ready = 1'b0;
        run_sched(16'h1200);
        r0 = bus.result;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd0;
        bus.cmd_data  = 16'h0300;
        for (int s = 0; s < 5; s++) begin
            chk($sformatf("bp_stable%0d", s), 32'(bus.result), 32'(r0));
            chk($sformatf("bp_stall%0d", s), {23'd0, bus.cmd_ready, bus.param_write}, 32'd0);
            @(negedge clk);
            #1;
        end
        chk("bp_valid_held", 32'(bus.result_valid), 32'd1);
        bus.result_ready = 1'b1;
        chk("bp_hs_stall", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("bp_accept", {23'd0, bus.cmd_ready, bus.param_write}, {23'd0, 1'b1, 8'h01});
        @(negedge clk);
        bus.cmd_valid = 1'b0;

        // 9th LOAD_VAL wraps to row 0; row0 = [3,1,1,1].[2,3,4,2] = 15, row1 = 8
        cmd(2'd1, 16'h0200, 8'h00, 2'b01, "val_wrap");
        run_sched(16'h1700);
        @(negedge clk);

        // CLEAR after three more values resets both pointers
        for (int j = 0; j < 3; j++) cmd(2'd1, 16'h0100, 8'h00, 2'b01, $sformatf("preclr%0d", j));
        cmd(2'd3, 16'h0000, 8'h00, 2'b00, "clear");
        cmd(2'd1, 16'h0100, 8'h00, 2'b01, "clr_val");
        cmd(2'd0, 16'h0100, 8'h01, 2'b00, "clr_param");

        // Reset during ACC0 aborts the run
        cmd(2'd2, 16'h0000, 8'h00, 2'b00, "run_abort");
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("in_acc0", {29'd0, bus.mul_en, bus.accumulate_en}, 32'b001);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_strobes", {20'd0, bus.param_write, bus.val_shift, bus.mul_en,
                              bus.mul_row_sel, bus.accumulate_en}, 32'd0);
        chk("abort_idle", {30'd0, bus.cmd_ready, bus.result_valid}, 32'b10);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (bus.result_valid) seen = 1'b1;
        end
        chk("abort_no_result", 32'(seen), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
